ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver, the successor to the team's release-only scancode grabber.
- Filters and edge-detects ps2clk, then deframes 11-bit packets (start, 8 data LSB-first, odd parity, stop).
- Decodes E0 (extended) and F0 (break) prefixes and reports both make and break events.
- Buffers events in a small FIFO with a valid/ready output handshake.
- Flags parity, framing, timeout and overflow errors.
- Sits between the PS/2 pins and the game/control logic.

Parameters:
- SYNC_LEN, 8: ps2clk sample-history length; must be even and ≥4.
- TIMEOUT_CYC, 50000: clk cycles without a ps2clk falling edge, mid-frame, before the frame is aborted.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two, ≥2.
- REPORT_MAKE, 1: 1 reports make and break events; 0 reports break events only.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2clk  in  1  raw PS/2 clock pin
- ps2data  in  1  raw PS/2 data pin
- ev_valid  out  1  FIFO head is valid
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  8  scancode at the FIFO head
- ev_break  out  1  head event is a key release
- ev_ext  out  1  head event is E0-prefixed
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of buffered events
- err_parity  out  1  one-cycle pulse
- err_frame  out  1  one-cycle pulse
- err_timeout  out  1  one-cycle pulse
- overflow  out  1  one-cycle pulse

Behaviour:
- Reset: a single synchronous, active-high reset on one clock, applied mid-frame or not. It clears:
  - the sample history (to all zeros), the 2-flop ps2data synchroniser (to 1), the shift register and bit counter, the timeout counter;
  - the ext/brk prefix flags and the FIFO;
  - all error and overflow pulses, ev_valid and fifo_count, which read 0 the cycle after reset.
  - ev_code, ev_break and ev_ext are don't-care while ev_valid=0.
- Edge detect: fall_edge=1 when the upper SYNC_LEN/2 samples are all 1 and the lower SYNC_LEN/2 are all 0. It is high for exactly one cycle per edge. Data bits are taken from the synchronised ps2data.
- Frame FSM:
  - IDLE: on fall_edge, if data=0 go to RECV with cnt=1. If data=1, stay in IDLE with no error.
  - RECV: on each fall_edge, shift the bit in LSB-first and increment cnt. The 10th edge captures parity; go to STOP.
  - STOP: on the 11th fall_edge, return to IDLE and evaluate the frame:
    - stop bit=0 → err_frame;
    - otherwise, XOR of data and parity ≠1 → err_parity;
    - otherwise the byte is valid.
    - Any error also clears the prefix flags.
- Timeout: the counter clears on every fall_edge and while in IDLE. In RECV or STOP, when it reaches TIMEOUT_CYC-1, the FSM returns to IDLE, pulses err_timeout and clears the prefix flags.
- Decoder, valid bytes only:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte forms the event {ext, brk, code} and clears both flags.
  - The event is pushed unless brk=0 and REPORT_MAKE=0.
- Latency: ev_valid rises on the cycle after the clk edge that samples the stop-bit fall_edge, if the FIFO was empty.
- FIFO: first-word-fall-through, entry width 10.
  - Pop when ev_valid & ev_ready.
  - Push while full without a same-cycle pop: the new event is dropped and overflow pulses.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
PS2_KBD_RX_TYPEMATIC_FILTER_EN
- Defined: a held-key register {ext, code, valid} suppresses auto-repeat.
  - A make event equal to the held key is dropped; a different make replaces the held key.
  - A break event matching the held key clears it.
  - Breaks are always reported.
- Undefined: every make is reported, including repeats.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0;
  - the event bit layout: [9]=ext, [8]=brk, [7:0]=code;
  - the frame length constant of 11.
- Sub-module ps2_ev_fifo: a parametrised synchronous FWFT FIFO (width, depth, with count and overflow).

Test Plan:
1. Frame 0x1C (parity 0), then F0, then 1C, with ev_ready=1 → two events: {code=1C, brk=0, ext=0} and {code=1C, brk=1, ext=0}.
2. E0, F0, 75 → one event {code=75, brk=1, ext=1}; with REPORT_MAKE=0, E0 75 produces no event.
3. 0x1C sent with parity bit 1 → err_parity pulses once and no event; stop bit 0 → err_frame pulses once.
4. Hold ps2clk high after 5 bits for TIMEOUT_CYC cycles → err_timeout pulses once and the FSM returns to IDLE; the next clean 0x29 frame decodes correctly.
5. ev_ready=0, five makes (15, 1D, 24, 2D, 2C) with FIFO_DEPTH=4 → fifo_count=4, overflow pulses once, drain order 15, 1D, 24, 2D.
6. Macro defined: 1C, 1C, 1C, F0 1C → exactly two events (make 1C, break 1C). Macro undefined → four events.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, event layout and frame state for the PS/2 keyboard receiver
package ps2_pkg;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
   localparam int         PS2_FRAME_LEN  = 11;

   // Event word layout: [9]=ext, [8]=brk, [7:0]=code
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   localparam int PS2_EV_W = $bits(ps2_event_t);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_STOP = 2'd2
   } frame_state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// rtl/ps2_ev_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count and overflow pulse
module ps2_ev_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_valid,
   input  logic [WIDTH-1:0]               wr_data,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic [WIDTH-1:0]               rd_data,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign rd_valid = (count_q != '0);
   assign full     = (count_q == CW'(DEPTH));
   assign do_pop   = rd_valid && rd_ready;
   // A pop frees the slot in the same cycle, so a push into a full FIFO still lands
   assign do_push  = wr_valid && (!full || do_pop);
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q  <= count_q + CW'(do_push) - CW'(do_pop);
         overflow <= wr_valid && full && !do_pop;
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: clock filter, deframer, E0/F0 decoder and event FIFO
// Optional auto-repeat suppression is built when PS2_KBD_RX_TYPEMATIC_FILTER_EN is defined.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_LEN    = 8,
   parameter int TIMEOUT_CYC = 50000,
   parameter int FIFO_DEPTH  = 4,
   parameter int REPORT_MAKE = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ps2clk,
   input  logic                              ps2data,
   output logic                              ev_valid,
   input  logic                              ev_ready,
   output logic [7:0]                        ev_code,
   output logic                              ev_break,
   output logic                              ev_ext,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              err_parity,
   output logic                              err_frame,
   output logic                              err_timeout,
   output logic                              overflow
);
   localparam int HALF = SYNC_LEN / 2;
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_LEN-1:0] hist_q;
   logic [1:0]          data_sync_q;
   logic                fall_edge;
   logic                data_bit;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q      <= '0;
         data_sync_q <= 2'b11;
      end else begin
         hist_q      <= {hist_q[SYNC_LEN-2:0], ps2clk};
         data_sync_q <= {data_sync_q[0], ps2data};
      end
   end

   // Older half high and newer half low: one settled falling edge, seen for a single cycle
   assign fall_edge = (hist_q[SYNC_LEN-1:HALF] == '1) && (hist_q[HALF-1:0] == '0);
   assign data_bit  = data_sync_q[1];

   frame_state_t  state_q;
   frame_state_t  state_d;
   logic [3:0]    cnt_q;
   logic [7:0]    shift_q;
   logic          parity_q;
   logic [TW-1:0] tmo_q;
   logic          tmo_hit;
   logic          frame_end;
   logic          frame_ok;
   logic          frame_bad_stop;
   logic          frame_bad_par;

   assign tmo_hit = (state_q != ST_IDLE) && !fall_edge && (tmo_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (fall_edge && !data_bit) state_d = ST_RECV;
         ST_RECV: begin
            if (tmo_hit) begin
               state_d = ST_IDLE;
            end else if (fall_edge && cnt_q == 4'(PS2_FRAME_LEN - 2)) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: if (tmo_hit || fall_edge) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      frame_end      = (state_q == ST_STOP) && fall_edge;
      frame_bad_stop = frame_end && !data_bit;
      frame_bad_par  = frame_end && data_bit && !odd_parity_ok(shift_q, parity_q);
      frame_ok       = frame_end && data_bit && odd_parity_ok(shift_q, parity_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tmo_q    <= '0;
      end else begin
         if (state_q == ST_IDLE || fall_edge) begin
            tmo_q <= '0;
         end else begin
            tmo_q <= tmo_q + TW'(1);
         end
         if (fall_edge) begin
            case (state_q)
               ST_IDLE: cnt_q <= 4'd1;
               ST_RECV: begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'(PS2_FRAME_LEN - 2)) begin
                     parity_q <= data_bit;
                  end else begin
                     shift_q <= {data_bit, shift_q[7:1]};
                  end
               end
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

   logic       ext_q;
   logic       brk_q;
   logic       is_prefix;
   logic       report;
   logic       ev_push;
   logic       any_err;
   ps2_event_t ev_new;
   ps2_event_t ev_head;

   assign is_prefix = (shift_q == PS2_EXT_PREFIX) || (shift_q == PS2_BRK_PREFIX);
   assign any_err   = frame_bad_stop || frame_bad_par || tmo_hit;
   assign ev_new    = '{ext: ext_q, brk: brk_q, code: shift_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (any_err) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (frame_ok) begin
         if (shift_q == PS2_EXT_PREFIX) begin
            ext_q <= 1'b1;
         end else if (shift_q == PS2_BRK_PREFIX) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

`ifdef PS2_KBD_RX_TYPEMATIC_FILTER_EN
   logic       held_v_q;
   logic       held_ext_q;
   logic [7:0] held_code_q;
   logic       held_match;

   assign held_match = held_v_q && (held_ext_q == ext_q) && (held_code_q == shift_q);

   // The held key tracks the last make even if its event was dropped by a full FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         held_v_q    <= 1'b0;
         held_ext_q  <= 1'b0;
         held_code_q <= '0;
      end else if (frame_ok && !is_prefix) begin
         if (brk_q) begin
            if (held_match) begin
               held_v_q <= 1'b0;
            end
         end else begin
            held_v_q    <= 1'b1;
            held_ext_q  <= ext_q;
            held_code_q <= shift_q;
         end
      end
   end

   assign report = brk_q || ((REPORT_MAKE != 0) && !held_match);
`else
   assign report = brk_q || (REPORT_MAKE != 0);
`endif

   assign ev_push = frame_ok && !is_prefix && report;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_parity  <= frame_bad_par;
         err_frame   <= frame_bad_stop;
         err_timeout <= tmo_hit;
      end
   end

   ps2_ev_fifo #(
      .WIDTH (PS2_EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (ev_push),
      .wr_data  (ev_new),
      .rd_valid (ev_valid),
      .rd_ready (ev_ready),
      .rd_data  (ev_head),
      .count    (fifo_count),
      .overflow (overflow)
   );

   assign ev_code  = ev_head.code;
   assign ev_break = ev_head.brk;
   assign ev_ext   = ev_head.ext;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - randomized self-checking bench for ps2_kbd_rx against a keyboard-event model
module tb_ps2_kbd_rx;
   localparam int SYNC_LEN    = 8;
   localparam int TIMEOUT_CYC = 200;
   localparam int FIFO_DEPTH  = 4;
   localparam int H           = 12;
   localparam int CW          = $clog2(FIFO_DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ps2clk = 1'b1;
   logic          ps2data = 1'b1;
   logic          ev_ready = 1'b1;
   logic          ev_ready2 = 1'b1;
   logic          ev_valid, ev_break, ev_ext;
   logic [7:0]    ev_code;
   logic [CW-1:0] fifo_count;
   logic          err_parity, err_frame, err_timeout, overflow;
   logic          ev_valid2, ev_break2, ev_ext2;
   logic [7:0]    ev_code2;
   logic [CW-1:0] fifo_count2;
   logic          err_parity2, err_frame2, err_timeout2, overflow2;

   always #5 clk = ~clk;

   ps2_kbd_rx #(.SYNC_LEN(SYNC_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH), .REPORT_MAKE(1)) dut (
      .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_break(ev_break), .ev_ext(ev_ext),
      .fifo_count(fifo_count), .err_parity(err_parity), .err_frame(err_frame),
      .err_timeout(err_timeout), .overflow(overflow));

   ps2_kbd_rx #(.SYNC_LEN(SYNC_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH), .REPORT_MAKE(0)) dut_brk (
      .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
      .ev_valid(ev_valid2), .ev_ready(ev_ready2), .ev_code(ev_code2), .ev_break(ev_break2), .ev_ext(ev_ext2),
      .fifo_count(fifo_count2), .err_parity(err_parity2), .err_frame(err_frame2),
      .err_timeout(err_timeout2), .overflow(overflow2));

   int         checks = 0;
   int         errors = 0;
   int         n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0;
   logic [9:0] got[$], got2[$], exp_q[$], exp2_q[$];
   logic       m_ext, m_brk, m_held_v;
   logic [8:0] m_held;
   bit         rnd_ready = 0;
   int         last_lat;

   always @(negedge clk) begin
      if (!reset) begin
         if (ev_valid && ev_ready) got.push_back({ev_ext, ev_break, ev_code});
         if (ev_valid2 && ev_ready2) got2.push_back({ev_ext2, ev_break2, ev_code2});
         if (err_parity) n_par++;
         if (err_frame) n_frm++;
         if (err_timeout) n_tmo++;
         if (overflow) n_ovf++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish, required finish before 5000000");
      $fatal(1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Keyboard-level model: prefixes accumulate, any other byte completes one key event
   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_held_v = 0; m_held = '0;
   endtask

   task automatic model_err();
      m_ext = 0; m_brk = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [9:0] ev;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         ev = {m_ext, m_brk, b};
         if (m_brk) begin
            exp_q.push_back(ev);
            exp2_q.push_back(ev);
            if (m_held_v && m_held == {m_ext, b}) m_held_v = 0;
         end else begin
`ifdef PS2_KBD_RX_TYPEMATIC_FILTER_EN
            if (!(m_held_v && m_held == {m_ext, b})) exp_q.push_back(ev);
            m_held_v = 1;
            m_held = {m_ext, b};
`else
            exp_q.push_back(ev);
`endif
         end
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input bit pflip, input bit stopb, input int nbits);
      logic [10:0] fr;
      fr = {stopb, (~^b) ^ pflip, b, 1'b0};
      last_lat = 0;
      for (int i = 0; i < nbits; i++) begin
         ps2data = fr[i];
         if (rnd_ready) ev_ready = 1'($urandom % 2);
         wait_cyc(H);
         ps2clk = 1'b0;
         if (i == 10) begin
            for (int k = 1; k <= H; k++) begin
               @(posedge clk);
               @(negedge clk);
               if (last_lat == 0 && ev_valid) last_lat = k;
            end
            wait_cyc(1);
         end else begin
            wait_cyc(H);
         end
         ps2clk = 1'b1;
      end
      wait_cyc(H);
      ps2data = 1'b1;
   endtask

   task automatic key(input logic [7:0] b);
      model_byte(b);
      send_bits(b, 0, 1, 11);
   endtask

   task automatic clear_q();
      got.delete(); got2.delete(); exp_q.delete(); exp2_q.delete();
   endtask

   task automatic test_reset();
      reset = 1;
      wait_cyc(3);
      checks++;
      if ({ev_valid, fifo_count, err_parity, err_frame, err_timeout, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs valid=%0b count=%0d errs=%0b%0b%0b ovf=%0b, required all 0",
                  ev_valid, fifo_count, err_parity, err_frame, err_timeout, overflow);
      end
      reset = 0;
      model_reset();
      ev_ready = 0;
      key(8'h1C);
      key(8'hE0);
      send_bits(8'h5A, 0, 1, 4);
      reset = 1;
      wait_cyc(1);
      reset = 0;
      checks++;
      if (ev_valid !== 1'b0 || fifo_count !== '0) begin
         errors++;
         $display("FAIL midframe_reset valid=%0b count=%0d, required 0 0", ev_valid, fifo_count);
      end
      model_reset();
      clear_q();
      ev_ready = 1;
      key(8'h29);
      wait_cyc(4);
      checks++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL after_reset_event got %0d events head %h, required 1 event %h",
                  got.size(), (got.size() > 0) ? got[0] : 10'h0, exp_q[0]);
      end
   endtask

   task automatic test_make_break();
      clear_q();
      ev_ready = 1;
      key(8'h1C);
      checks++;
      if (last_lat != SYNC_LEN / 2 + 1) begin
         errors++;
         $display("FAIL latency got %0d cycles, required %0d", last_lat, SYNC_LEN / 2 + 1);
      end
      key(8'hF0);
      key(8'h1C);
      wait_cyc(4);
      checks++;
      if (exp_q.size() != 2 || got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL make_break_count got %0d expected %0d required 2", got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL make_break_ev%0d got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (got2.size() != 1 || got2[0] !== 10'h11C) begin
         errors++;
         $display("FAIL brk_only_1c got %0d events, required 1 event 11c", got2.size());
      end
   endtask

   task automatic test_extended();
      clear_q();
      key(8'hE0); key(8'hF0); key(8'h75);
      key(8'hE0); key(8'h75);
      wait_cyc(4);
      checks++;
      if (got.size() != exp_q.size() || got.size() != 2 || got[0] !== 10'h375) begin
         errors++;
         $display("FAIL ext_events got %0d events head %h, required 2 events head 375",
                  got.size(), (got.size() > 0) ? got[0] : 10'h0);
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ext_ev%0d got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (got2.size() != 1 || got2[0] !== exp2_q[0]) begin
         errors++;
         $display("FAIL ext_brk_only got %0d events, required 1 event %h", got2.size(), exp2_q[0]);
      end
   endtask

   task automatic test_errors();
      int p0, f0;
      clear_q();
      p0 = n_par; f0 = n_frm;
      key(8'hF0);
      send_bits(8'h1C, 1, 1, 11); model_err();
      key(8'h1C);
      send_bits(8'h1C, 0, 0, 11); model_err();
      wait_cyc(4);
      checks++;
      if (n_par - p0 != 1) begin
         errors++;
         $display("FAIL err_parity_pulses got %0d, required 1", n_par - p0);
      end
      checks++;
      if (n_frm - f0 != 1) begin
         errors++;
         $display("FAIL err_frame_pulses got %0d, required 1", n_frm - f0);
      end
      checks++;
      if (got.size() != exp_q.size() || got.size() != 1 || got[0] !== 10'h01C) begin
         errors++;
         $display("FAIL err_events got %0d events head %h, required 1 event 01c",
                  got.size(), (got.size() > 0) ? got[0] : 10'h0);
      end
   endtask

   task automatic test_timeout();
      int t0, w;
      clear_q();
      t0 = n_tmo;
      send_bits(8'h6B, 0, 1, 5);
      wait_cyc(TIMEOUT_CYC / 2);
      checks++;
      if (n_tmo != t0) begin
         errors++;
         $display("FAIL timeout_early got %0d pulses, required 0", n_tmo - t0);
      end
      w = 0;
      while (n_tmo == t0 && w < TIMEOUT_CYC + 4 * H) begin
         wait_cyc(1);
         w++;
      end
      wait_cyc(4);
      model_err();
      checks++;
      if (n_tmo - t0 != 1) begin
         errors++;
         $display("FAIL timeout_pulses got %0d, required 1", n_tmo - t0);
      end
      key(8'h29);
      wait_cyc(4);
      checks++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL timeout_recover got %0d events, required 1 event %h", got.size(), exp_q[0]);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      int o0;
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      clear_q();
      o0 = n_ovf;
      ev_ready = 0;
      for (int i = 0; i < 5; i++) key(codes[i]);
      while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
      checks++;
      if (fifo_count !== CW'(FIFO_DEPTH)) begin
         errors++;
         $display("FAIL full_count got %0d, required %0d", fifo_count, FIFO_DEPTH);
      end
      checks++;
      if (n_ovf - o0 != 1) begin
         errors++;
         $display("FAIL overflow_pulses got %0d, required 1", n_ovf - o0);
      end
      ev_ready = 1;
      wait_cyc(FIFO_DEPTH + 4);
      checks++;
      if (got.size() != FIFO_DEPTH || fifo_count !== '0) begin
         errors++;
         $display("FAIL drain got %0d events count %0d, required %0d events count 0",
                  got.size(), fifo_count, FIFO_DEPTH);
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== {2'b00, codes[i]}) begin
            errors++;
            $display("FAIL drain_ev%0d got %h, required %h", i, got[i], {2'b00, codes[i]});
         end
      end
   endtask

   task automatic test_typematic();
      int need;
`ifdef PS2_KBD_RX_TYPEMATIC_FILTER_EN
      need = 2;
`else
      need = 4;
`endif
      clear_q();
      key(8'h1C); key(8'h1C); key(8'h1C); key(8'hF0); key(8'h1C);
      wait_cyc(4);
      checks++;
      if (got.size() != need || exp_q.size() != need) begin
         errors++;
         $display("FAIL typematic_count got %0d model %0d, required %0d", got.size(), exp_q.size(), need);
      end
      checks++;
      if (got.size() > 0 && got[got.size() - 1] !== 10'h11C) begin
         errors++;
         $display("FAIL typematic_last got %h, required 11c", got[got.size() - 1]);
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [4];
      int r;
      pool = '{8'h1C, 8'h32, 8'h21, 8'h23};
      clear_q();
      rnd_ready = 1;
      for (int n = 0; n < 40; n++) begin
         r = $urandom % 10;
         if (r == 0) begin
            send_bits(pool[$urandom % 4], 1, 1, 11); model_err();
         end else if (r == 1) begin
            send_bits(pool[$urandom % 4], 0, 0, 11); model_err();
         end else begin
            if ($urandom % 3 == 0) key(8'hE0);
            if ($urandom % 2 == 0) key(8'hF0);
            key(pool[$urandom % 4]);
         end
      end
      rnd_ready = 0;
      ev_ready = 1;
      wait_cyc(FIFO_DEPTH + 4);
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_count got %0d, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random_ev%0d got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (got2.size() != exp2_q.size()) begin
         errors++;
         $display("FAIL random_brk_count got %0d, required %0d", got2.size(), exp2_q.size());
      end
      for (int i = 0; i < got2.size() && i < exp2_q.size(); i++) begin
         checks++;
         if (got2[i] !== exp2_q[i]) begin
            errors++;
            $display("FAIL random_brk_ev%0d got %h, required %h", i, got2[i], exp2_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_extended();
      test_errors();
      test_timeout();
      test_overflow();
      test_typematic();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
